// File: rtl/dice_roller.sv
// dice_roller: turns the free-running 3-bit rng stream into a fair pair of
// six-sided dice. Out-of-range samples (0, 7) are re-drawn up to MAX_REJECT
// times per die, after which the sample is force-mapped (0->1, 7->6) so every
// roll completes in bounded time. Results are delivered with a one-cycle
// roll_valid pulse and held until the next completed roll.
//
// Optional feature: define DICE_DOUBLES_EN to add the doubles / doubles_cnt
// outputs (consecutive-doubles tracking). Without it those ports are absent.
module dice_roller #(
  parameter int unsigned MAX_REJECT = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rand_in,
  input  logic       roll_req,
  output logic       busy,
  output logic       roll_valid,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum
`ifdef DICE_DOUBLES_EN
  ,
  output logic       doubles,
  output logic [1:0] doubles_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIE1 = 2'd1;
  localparam logic [1:0] S_DIE2 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] LP_MAX_REJECT = MAX_REJECT[3:0];

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_rej_cnt;
  logic [2:0] r_die1;
  logic [2:0] r_die2;
  logic [3:0] r_sum;

  logic       w_in_range;
  logic       w_at_limit;
  logic       w_capture;
  logic [2:0] w_die_val;
  logic       w_rolling;

`ifdef DICE_DOUBLES_EN
  logic       r_doubles;
  logic [1:0] r_doubles_cnt;
  logic       w_is_double;
`endif

  // Classify the current sample and decide the value a capture would take.
  always_comb begin
    w_in_range = (rand_in != 3'd0) && (rand_in != 3'd7);
    w_at_limit = (r_rej_cnt >= LP_MAX_REJECT);
    w_rolling  = (r_state == S_DIE1) || (r_state == S_DIE2);
    w_capture  = w_rolling && (w_in_range || w_at_limit);
    if (w_in_range) begin
      w_die_val = rand_in;
    end else if (rand_in == 3'd0) begin
      w_die_val = 3'd1;
    end else begin
      w_die_val = 3'd6;
    end
  end

  // Next-state selection: each die state exits on a capture, DONE always
  // returns to IDLE so roll_req is only ever looked at from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (roll_req) w_state_nxt = S_DIE1;
      S_DIE1:  if (w_capture) w_state_nxt = S_DIE2;
      S_DIE2:  if (w_capture) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Reject counter: counts consecutive rejections for the die being drawn,
  // cleared on entry to DIE1 and on every capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rej_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_rej_cnt <= '0;
    end else if (w_capture) begin
      r_rej_cnt <= '0;
    end else if (w_rolling) begin
      r_rej_cnt <= r_rej_cnt + 4'd1;
    end
  end

  // First die capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_die1 <= '0;
    end else if (w_capture && (r_state == S_DIE1)) begin
      r_die1 <= w_die_val;
    end
  end

  // Second die capture; sum is formed from the value being captured this edge
  // so it lands together with die2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_die2 <= '0;
      r_sum  <= '0;
    end else if (w_capture && (r_state == S_DIE2)) begin
      r_die2 <= w_die_val;
      r_sum  <= {1'b0, r_die1} + {1'b0, w_die_val};
    end
  end

`ifdef DICE_DOUBLES_EN
  always_comb begin
    w_is_double = (r_die1 == w_die_val);
  end

  // Doubles flag and saturating consecutive-doubles count, updated with sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_doubles     <= 1'b0;
      r_doubles_cnt <= '0;
    end else if (w_capture && (r_state == S_DIE2)) begin
      r_doubles <= w_is_double;
      if (!w_is_double) begin
        r_doubles_cnt <= '0;
      end else if (r_doubles_cnt != 2'd3) begin
        r_doubles_cnt <= r_doubles_cnt + 2'd1;
      end
    end
  end

  assign doubles     = r_doubles;
  assign doubles_cnt = r_doubles_cnt;
`endif

  assign busy       = w_rolling;
  assign roll_valid = (r_state == S_DONE);
  assign die1       = r_die1;
  assign die2       = r_die2;
  assign sum        = r_sum;

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: each directed roll pushes its expected
// dice, sum and the cycle on which roll_valid must appear; a monitor pops and
// checks whenever roll_valid is seen.
module tb_dice_roller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rand_in;
  logic       roll_req;
  logic       busy;
  logic       roll_valid;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [3:0] sum;
`ifdef DICE_DOUBLES_EN
  logic       doubles;
  logic [1:0] doubles_cnt;
`endif

  dice_roller #(.MAX_REJECT(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .rand_in    (rand_in),
    .roll_req   (roll_req),
    .busy       (busy),
    .roll_valid (roll_valid),
    .die1       (die1),
    .die2       (die2),
    .sum        (sum)
`ifdef DICE_DOUBLES_EN
    ,
    .doubles    (doubles),
    .doubles_cnt(doubles_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] d1;
    logic [2:0] d2;
    logic [3:0] s;
    int         at_cyc;
    logic       dbl;
    logic [1:0] dcnt;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] sv[$];
  int         errs   = 0;
  int         checks = 0;
  logic       prev_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every roll_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (roll_valid) begin
      chk("valid_one_cycle", int'(prev_valid), 0);
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_valid: got roll_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("die1", int'(die1), int'(e.d1));
        chk("die2", int'(die2), int'(e.d2));
        chk("sum", int'(sum), int'(e.s));
        chk("valid_cycle", cyc, e.at_cyc);
`ifdef DICE_DOUBLES_EN
        chk("doubles", int'(doubles), int'(e.dbl));
        chk("doubles_cnt", int'(doubles_cnt), int'(e.dcnt));
`endif
      end
    end
    prev_valid = roll_valid;
  end

  // One roll: request for one cycle, then feed the queued samples one per edge.
  task automatic roll(input logic [2:0] d1, input logic [2:0] d2, input logic [3:0] s,
                      input logic dbl, input logic [1:0] dcnt);
    exp_t e;
    e.d1 = d1; e.d2 = d2; e.s = s; e.dbl = dbl; e.dcnt = dcnt;
    e.at_cyc = cyc + 1 + sv.size();
    sb.push_back(e);
    roll_req = 1'b1;
    @(posedge clk); #1;
    roll_req = 1'b0;
    chk("busy_in_roll", int'(busy), 1);
    while (sv.size() > 0) begin
      rand_in = sv.pop_front();
      @(posedge clk); #1;
    end
    rand_in = 3'd5;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) sv.push_back(v);
  endtask

  initial begin
    logic [2:0] bb [7];
    exp_t       e;
    int         c;

    reset    = 1'b0;
    rand_in  = 3'd5;
    roll_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(roll_valid), 0);
    chk("rst_die1", int'(die1), 0);
    chk("rst_die2", int'(die2), 0);
    chk("rst_sum", int'(sum), 0);
    @(posedge clk); #1;
    roll_req = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;

    // Clean roll: 3 then 4.
    sv.push_back(3'd3); sv.push_back(3'd4);
    roll(3'd3, 3'd4, 4'd7, 1'b0, 2'd0);
    @(negedge clk);
    chk("hold_die1", int'(die1), 3);
    chk("hold_sum", int'(sum), 7);
    chk("idle_busy", int'(busy), 0);
    @(posedge clk); #1;

    // Two rejections on die1.
    sv.push_back(3'd0); sv.push_back(3'd7); sv.push_back(3'd2); sv.push_back(3'd6);
    roll(3'd2, 3'd6, 4'd8, 1'b0, 2'd0);

    // Seven rejections then an in-range sample exactly at the limit.
    push_n(3'd0, 7); sv.push_back(3'd3); sv.push_back(3'd4);
    roll(3'd3, 3'd4, 4'd7, 1'b0, 2'd0);

    // Forced mapping, 7 -> 6 on both dice.
    push_n(3'd7, 16);
    roll(3'd6, 3'd6, 4'd12, 1'b1, 2'd1);

    // Forced mapping, 0 -> 1 on both dice.
    push_n(3'd0, 16);
    roll(3'd1, 3'd1, 4'd2, 1'b1, 2'd2);

    // Back-to-back with roll_req held, dropped mid second roll.
    c = cyc;
    e.d1 = 3'd1; e.d2 = 3'd6; e.s = 4'd7;  e.at_cyc = c + 3; e.dbl = 1'b0; e.dcnt = 2'd0;
    sb.push_back(e);
    e.d1 = 3'd5; e.d2 = 3'd5; e.s = 4'd10; e.at_cyc = c + 7; e.dbl = 1'b1; e.dcnt = 2'd1;
    sb.push_back(e);
    bb = '{3'd5, 3'd1, 3'd6, 3'd5, 3'd5, 3'd5, 3'd5};
    roll_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rand_in = bb[i];
      @(posedge clk); #1;
      if (i == 4) roll_req = 1'b0;
    end
    rand_in = 3'd5;
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted while in DIE2: no valid, outputs cleared.
    roll_req = 1'b1;
    @(posedge clk); #1;
    roll_req = 1'b0;
    rand_in  = 3'd3;
    @(posedge clk); #1;
    chk("mid_busy_die2", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_die1", int'(die1), 0);
    @(negedge clk);
    chk("mid_rst_valid", int'(roll_valid), 0);
    chk("mid_rst_die2", int'(die2), 0);
    chk("mid_rst_sum", int'(sum), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Request after reset completes normally.
    sv.push_back(3'd2); sv.push_back(3'd5);
    roll(3'd2, 3'd5, 4'd7, 1'b0, 2'd0);

    // Doubles run: 2/2 x3, then 1/5.
    for (int i = 0; i < 3; i++) begin
      sv.push_back(3'd2); sv.push_back(3'd2);
      roll(3'd2, 3'd2, 4'd4, 1'b1, 2'(i + 1));
    end
    sv.push_back(3'd1); sv.push_back(3'd5);
    roll(3'd1, 3'd5, 4'd6, 1'b0, 2'd0);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dice_roller.md
Name: dice_roller

Overview:
- Consumer end of the `rng` generator. Takes the free-running 3-bit `rand` stream and turns it into a fair pair of six-sided dice for the game-turn logic.
- Out-of-range samples (0, 7) are rejected by sampling again. A bounded retry count guarantees forward progress.
- A request/valid handshake delivers die1, die2 and their sum to the turn controller.

Parameters:
- MAX_REJECT, default 7: consecutive rejected samples allowed per die before forced mapping. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rand_in  input  3  random sample from `rng`; may change every cycle.
- roll_req  input  1  request a new roll; level-sampled in IDLE only.
- busy  output  1  high while a roll is in progress (DIE1, DIE2).
- roll_valid  output  1  one-cycle pulse when die1/die2/sum are updated.
- die1  output  3  first die, 1..6.
- die2  output  3  second die, 1..6.
- sum  output  4  die1 + die2, 2..12.

Behaviour:
- Reset values (reset = 0, asynchronous): state = IDLE; busy = 0; roll_valid = 0; die1 = 0; die2 = 0; sum = 0; reject counter = 0. Outputs read 0 until the first completed roll.
- States are IDLE, DIE1, DIE2, DONE.
- IDLE:
  - roll_req = 1 at an edge → DIE1, reject counter cleared.
  - Otherwise stay in IDLE.
- DIE1, at each edge:
  - If rand_in is in 1..6: capture into die1, clear the counter, go to DIE2.
  - Else if counter < MAX_REJECT: increment the counter, stay in DIE1.
  - Else (counter == MAX_REJECT, sample still out of range): force-map 0→1, 7→6, capture into die1, clear the counter, go to DIE2.
- DIE2: same rules, capturing into die2. Exit goes to DONE, and sum is registered as die1 + die2 on that same edge (zero-extended to 4 bits).
- DONE: roll_valid = 1 for exactly this one cycle, then unconditional transition to IDLE. roll_req is ignored in DONE.
- busy = 1 in DIE1 and DIE2 only. roll_req is ignored while busy. Dropping roll_req mid-roll does not abort the roll.
- Latency:
  - With no rejections: roll_req seen at edge k → die1 captured at k+1 → die2 and sum at k+2 → roll_valid high from k+2 to k+3.
  - Each rejection adds one cycle. Worst case per roll is 2*(MAX_REJECT+1)+1 edges.
- Back-to-back rolls: with roll_req held high, the first roll_valid appears 3 edges after the first request, then one every 4 edges while no rejections occur (DONE→IDLE→DIE1 cost).
- die1, die2 and sum hold their values between rolls. They change only on capture edges.
- Reset asserted mid-roll returns immediately to the reset state. The partial roll is discarded and no roll_valid is produced.
- Reset deassertion is assumed synchronous to clk by the system reset synchronizer.

Optional Feature:
- Macro: DICE_DOUBLES_EN.
- Defined, adds two outputs:
  - `doubles` (1 bit): registered with sum; 1 when die1 == die2.
  - `doubles_cnt` (2 bits): consecutive doubles count. On each roll it increments when doubles, saturating at 3, and clears to 0 on a non-double roll. Both are 0 after reset.
- Not defined: these ports and their logic are absent. The rest of the block is identical.

Test Plan:
- Reset: hold reset = 0 with rand_in = 5 and roll_req = 1 for 3 cycles → busy = 0, roll_valid = 0, die1 = die2 = 0, sum = 0.
- Clean roll: rand_in = 3, then 4 on consecutive cycles, roll_req pulsed one cycle → die1 = 3, die2 = 4, sum = 7, roll_valid high exactly one cycle, 3 edges after the request.
- Rejection: rand_in = 0, 7, 2 for die1, then 6 for die2 → die1 = 2, die2 = 6, sum = 8, roll_valid delayed by exactly 2 cycles versus the clean case.
- Forced mapping: rand_in held at 7 with MAX_REJECT = 7 → die1 = 6 after 8 cycles in DIE1, die2 = 6, sum = 12. Repeat with rand_in held at 0 → die1 = die2 = 1, sum = 2.
- Reset mid-roll: assert reset while in DIE2 → state IDLE, no roll_valid, die1/die2/sum = 0. The next request completes normally.
- Doubles (DICE_DOUBLES_EN): three rolls of 2/2, then a roll of 1/5 → doubles_cnt = 1, 2, 3, 0 and doubles = 1, 1, 1, 0.
